// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the program-counter sequencer: next_sel codes and FSM state type.
package pc_sequencer_pkg;

   localparam logic [2:0] SEL_SEQ    = 3'd0;
   localparam logic [2:0] SEL_BRANCH = 3'd1;
   localparam logic [2:0] SEL_JUMP   = 3'd2;
   localparam logic [2:0] SEL_JUMPR  = 3'd3;
   localparam logic [2:0] SEL_CALL   = 3'd4;
   localparam logic [2:0] SEL_RET    = 3'd5;
   localparam logic [2:0] SEL_ERET   = 3'd6;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ISR    = 2'd1,
      ST_HALTED = 2'd2
   } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack with occupancy flags and a sticky overflow/underflow error.
module ret_stack #(
   parameter int ADDR_W      = 32,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              err
);

   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [ADDR_W-1:0] mem [STACK_DEPTH];
   logic [PTR_W:0]    count;
   logic [PTR_W-1:0]  top_idx;

   assign full    = (count == (PTR_W+1)'(STACK_DEPTH));
   assign empty   = (count == '0);
   assign top_idx = PTR_W'(count - 1'b1);
   assign dout    = mem[top_idx];

   // Overflowing pushes are dropped and underflowing pops leave the pointer alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         err   <= 1'b0;
      end else if (push) begin
         if (full) begin
            err <= 1'b1;
         end else begin
            mem[count[PTR_W-1:0]] <= din;
            count                 <= count + 1'b1;
         end
      end else if (pop) begin
         if (empty) err   <= 1'b1;
         else       count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, interrupt entry/return, halt, return stack.
//  state     | meaning
//  ST_RUN    | normal execution
//  ST_ISR    | executing interrupt handler, int_req ignored
//  ST_HALTED | pc frozen; halt_isr records whether it was entered from ISR
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                JUMP_W       = 26,
   parameter int                BRANCH_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] INT_VECTOR   = ADDR_W'(16),
   parameter int                STACK_DEPTH  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                halt,
   input  logic [2:0]          next_sel,
   input  logic                zero,
   input  logic [BRANCH_W-1:0] br_off,
   input  logic [JUMP_W-1:0]   j_target,
   input  logic [ADDR_W-1:0]   jr_target,
   input  logic                int_req,
   output logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   epc,
   output logic                int_ack,
   output logic                in_isr,
   output logic                stack_full,
   output logic                stack_empty,
   output logic                stack_err
);

   seq_state_t        state, state_nxt;
   logic              halt_isr, halt_isr_nxt;
   logic [ADDR_W-1:0] pc_nxt, epc_nxt;
   logic [ADDR_W-1:0] pc_plus1, br_target, j_addr, stack_top;
   logic              push, pop, int_entry;

   assign pc_plus1  = pc + 1'b1;
   assign br_target = pc_plus1 + ADDR_W'($signed(br_off));
   assign j_addr    = {pc_plus1[ADDR_W-1:JUMP_W], j_target};
   assign in_isr    = (state == ST_ISR) || ((state == ST_HALTED) && halt_isr);

   ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_plus1),
      .dout  (stack_top),
      .full  (stack_full),
      .empty (stack_empty),
      .err   (stack_err)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_RUN;
         halt_isr <= 1'b0;
         pc       <= RESET_VECTOR;
         epc      <= '0;
         int_ack  <= 1'b0;
      end else begin
         state    <= state_nxt;
         halt_isr <= halt_isr_nxt;
         pc       <= pc_nxt;
         epc      <= epc_nxt;
         int_ack  <= int_entry;
      end
   end

   always_comb begin
      state_nxt    = state;
      halt_isr_nxt = halt_isr;
      pc_nxt       = pc;
      epc_nxt      = epc;
      push         = 1'b0;
      pop          = 1'b0;
      int_entry    = 1'b0;
      if (int_req && !in_isr) begin
         // From RUN the interrupted instruction re-executes; from HALTED pc is already past halt.
         int_entry = 1'b1;
         pc_nxt    = INT_VECTOR;
         epc_nxt   = pc;
         state_nxt = ST_ISR;
      end else if (state == ST_HALTED) begin
         pc_nxt = pc;
      end else if (halt) begin
         pc_nxt       = pc_plus1;
         state_nxt    = ST_HALTED;
         halt_isr_nxt = (state == ST_ISR);
      end else begin
         case (next_sel)
            SEL_BRANCH: pc_nxt = zero ? br_target : pc_plus1;
            SEL_JUMP:   pc_nxt = j_addr;
            SEL_JUMPR:  pc_nxt = jr_target;
            SEL_CALL: begin
               push   = 1'b1;
               pc_nxt = j_addr;
            end
            SEL_RET: begin
               pop    = 1'b1;
               pc_nxt = stack_empty ? pc_plus1 : stack_top;
            end
            SEL_ERET: begin
               if (state == ST_ISR) begin
                  pc_nxt    = epc;
                  state_nxt = ST_RUN;
               end else begin
                  pc_nxt = pc_plus1;
               end
            end
            default:    pc_nxt = pc_plus1;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        halt;
   logic [2:0]  next_sel;
   logic        zero;
   logic [15:0] br_off;
   logic [25:0] j_target;
   logic [31:0] jr_target;
   logic        int_req;
   logic [31:0] pc, epc;
   logic        int_ack, in_isr, stack_full, stack_empty, stack_err;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .halt        (halt),
      .next_sel    (next_sel),
      .zero        (zero),
      .br_off      (br_off),
      .j_target    (j_target),
      .jr_target   (jr_target),
      .int_req     (int_req),
      .pc          (pc),
      .epc         (epc),
      .int_ack     (int_ack),
      .in_isr      (in_isr),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic op(input logic [2:0] sel);
      next_sel = sel;
      step();
   endtask

   task automatic jump_to(input logic [31:0] addr);
      jr_target = addr;
      op(SEL_JUMPR);
   endtask

   initial begin
      reset = 1'b1; halt = 1'b0; next_sel = SEL_SEQ; zero = 1'b0;
      br_off = '0; j_target = '0; jr_target = '0; int_req = 1'b0;
      step();
      step();
      check("rst_pc", pc, 32'd0);
      check("rst_epc", epc, 32'd0);
      check("rst_in_isr", {31'd0, in_isr}, 32'd0);
      check("rst_int_ack", {31'd0, int_ack}, 32'd0);
      check("rst_empty", {31'd0, stack_empty}, 32'd1);
      check("rst_full", {31'd0, stack_full}, 32'd0);
      check("rst_err", {31'd0, stack_err}, 32'd0);
      reset = 1'b0;

      for (int i = 1; i <= 3; i++) begin
         op(SEL_SEQ);
         check("seq_pc", pc, 32'(i));
      end
      op(3'd7);
      check("sel7_pc", pc, 32'd4);

      jump_to(32'hFFFF_FFFF);
      check("jr_pc", pc, 32'hFFFF_FFFF);
      op(SEL_SEQ);
      check("wrap_pc", pc, 32'd0);

      jump_to(32'd10);
      br_off = 16'hFFFD; zero = 1'b1;
      op(SEL_BRANCH);
      check("br_taken", pc, 32'd8);
      jump_to(32'd10);
      zero = 1'b0;
      op(SEL_BRANCH);
      check("br_not_taken", pc, 32'd11);

      jump_to(32'h1234_5678);
      j_target = 26'd7;
      op(SEL_JUMP);
      check("jump_upper", pc, 32'h1000_0007);

      jump_to(32'd5);
      j_target = 26'd100;
      op(SEL_CALL);
      check("call_pc", pc, 32'd100);
      check("call_nonempty", {31'd0, stack_empty}, 32'd0);
      op(SEL_RET);
      check("ret_pc", pc, 32'd6);
      check("ret_empty", {31'd0, stack_empty}, 32'd1);

      // pc=6: pushes 7,101,201,301; fifth push (401) is dropped
      for (int i = 1; i <= 5; i++) begin
         j_target = 26'(i * 100);
         op(SEL_CALL);
         check("call_chain_pc", pc, 32'(i * 100));
         if (i == 4) begin
            check("full_at_4", {31'd0, stack_full}, 32'd1);
            check("no_err_at_4", {31'd0, stack_err}, 32'd0);
         end
      end
      check("ovf_err", {31'd0, stack_err}, 32'd1);
      op(SEL_RET);
      check("pop_301", pc, 32'd301);
      op(SEL_RET);
      check("pop_201", pc, 32'd201);
      op(SEL_RET);
      check("pop_101", pc, 32'd101);
      op(SEL_RET);
      check("pop_7", pc, 32'd7);
      check("drained_empty", {31'd0, stack_empty}, 32'd1);

      reset = 1'b1; step(); reset = 1'b0;
      check("err_cleared", {31'd0, stack_err}, 32'd0);

      jump_to(32'd20);
      int_req = 1'b1;
      op(SEL_SEQ);
      check("int_pc", pc, 32'd16);
      check("int_epc", epc, 32'd20);
      check("int_ack_pulse", {31'd0, int_ack}, 32'd1);
      check("int_in_isr", {31'd0, in_isr}, 32'd1);
      op(SEL_SEQ);
      check("no_reentry_pc", pc, 32'd17);
      check("int_ack_drop", {31'd0, int_ack}, 32'd0);
      check("no_reentry_epc", epc, 32'd20);
      int_req = 1'b0;
      op(SEL_ERET);
      check("eret_pc", pc, 32'd20);
      check("eret_in_isr", {31'd0, in_isr}, 32'd0);
      op(SEL_ERET);
      check("eret_as_seq", pc, 32'd21);

      jump_to(32'd30);
      halt = 1'b1;
      op(SEL_SEQ);
      check("halt_pc", pc, 32'd31);
      halt = 1'b0;
      jr_target = 32'd99;
      for (int i = 0; i < 10; i++) op(SEL_JUMPR);
      check("halt_hold", pc, 32'd31);
      int_req = 1'b1;
      op(SEL_SEQ);
      check("halt_int_pc", pc, 32'd16);
      check("halt_int_epc", epc, 32'd31);
      int_req = 1'b0;
      op(SEL_ERET);
      check("halt_eret_pc", pc, 32'd31);

      // Halt from ISR: interrupts stay masked until reset.
      int_req = 1'b1;
      op(SEL_SEQ);
      check("isr2_pc", pc, 32'd16);
      halt = 1'b1;
      op(SEL_SEQ);
      halt = 1'b0;
      op(SEL_SEQ);
      op(SEL_SEQ);
      check("isr_halt_pc", pc, 32'd17);
      check("isr_halt_in_isr", {31'd0, in_isr}, 32'd1);
      int_req = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      check("isr_halt_rst_pc", pc, 32'd0);
      check("isr_halt_rst_isr", {31'd0, in_isr}, 32'd0);
      op(SEL_SEQ);
      check("post_rst_seq", pc, 32'd1);

      jump_to(32'd40);
      op(SEL_RET);
      check("unf_pc", pc, 32'd41);
      check("unf_err", {31'd0, stack_err}, 32'd1);
      check("unf_empty", {31'd0, stack_empty}, 32'd1);
      reset = 1'b1; step(); reset = 1'b0;
      check("unf_rst_err", {31'd0, stack_err}, 32'd0);
      check("unf_rst_pc", pc, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
